scalable_layer_search_ctrl: RTL and testbench

SCALABLE_LAYER_SEARCH_CTRL -- requirements
Module: scalable_layer_search_ctrl

---
 rtl/me_pkg.sv | 26 ++
 rtl/sad_min_tracker.sv | 43 ++++
 rtl/scalable_layer_search_ctrl.sv | 142 ++++++++++++++
 tb/tb_scalable_layer_search_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | me_pkg : shared encodings for the motion-estimation search control   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package me_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic [1:0] STEP_FULL = 2'd1;
    localparam logic [1:0] STEP_HALF = 2'd2;

    // Wide enough for any practical SAD width; users slice the low bits.
    localparam int                     SAD_W_MAX    = 64;
    localparam logic [SAD_W_MAX-1:0]   SAD_ALL_ONES = '1;

    function automatic logic [1:0] step_sel(input logic step2);
        return step2 ? STEP_HALF : STEP_FULL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sad_min_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sad_min_tracker : running minimum SAD and its position, one partition|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sad_min_tracker
    import me_pkg::*;
#(
    parameter int SAD_W = 18,
    parameter int COL_W = 5,
    parameter int ROW_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             update_en,
    input  logic [SAD_W-1:0] sad_in,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    output logic [SAD_W-1:0] best_sad,
    output logic [COL_W-1:0] best_col,
    output logic [ROW_W-1:0] best_row
);

    localparam logic [SAD_W-1:0] SAD_INIT = SAD_ALL_ONES[SAD_W-1:0];

    // Strict less-than keeps the earliest candidate in raster order on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad <= SAD_INIT;
            best_col <= '0;
            best_row <= '0;
        end else if (init) begin
            best_sad <= SAD_INIT;
        end else if (update_en && (sad_in < best_sad)) begin
            best_sad <= sad_in;
            best_col <= col;
            best_row <= row;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scalable_layer_search_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scalable_layer_search_ctrl : raster search sequencer with per-       |
// | partition minimum-SAD tracking.                          Rev 1.0     |
// +----------------------------------------------------------------------+
module scalable_layer_search_ctrl
    import me_pkg::*;
#(
    parameter int NUM_PART = 7,
    parameter int SAD_W    = 18,
    parameter int COL_W    = 5,
    parameter int ROW_W    = 7,
    parameter int PREP_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [COL_W-1:0]          search_w,
    input  logic [ROW_W-1:0]          search_h,
    input  logic                      step2,
    input  logic                      sad_valid,
    input  logic [NUM_PART*SAD_W-1:0] sad_in,
    output logic                      ref_begin_prepare,
    output logic                      pe_begin_prepare,
    output logic [COL_W-1:0]          search_column_count,
    output logic [ROW_W-1:0]          search_row_count,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_PART*SAD_W-1:0] best_sad,
    output logic [NUM_PART*COL_W-1:0] best_col,
    output logic [NUM_PART*ROW_W-1:0] best_row
);

    localparam int PW = $clog2(PREP_CYC + 1);

    state_t           state;
    logic [1:0]       step_r;
    logic [COL_W-1:0] w_lat;
    logic [ROW_W-1:0] h_lat;
    logic [PW-1:0]    prep_cnt;
    logic [COL_W:0]   col_nxt;
    logic [ROW_W:0]   row_nxt;
    logic             scan_init;
    logic             update_en;

    assign col_nxt   = {1'b0, search_column_count} + (COL_W+1)'(step_r);
    assign row_nxt   = {1'b0, search_row_count} + (ROW_W+1)'(step_r);
    assign scan_init = (state == ST_PREP) && !abort && (prep_cnt == PW'(PREP_CYC - 1));
    assign update_en = (state == ST_SCAN) && sad_valid && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            step_r              <= STEP_FULL;
            w_lat               <= '0;
            h_lat               <= '0;
            prep_cnt            <= '0;
            search_column_count <= '0;
            search_row_count    <= '0;
            ref_begin_prepare   <= 1'b0;
            pe_begin_prepare    <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            ref_begin_prepare <= 1'b0;
            pe_begin_prepare  <= 1'b0;
            done              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        w_lat             <= search_w;
                        h_lat             <= search_h;
                        step_r            <= step_sel(step2);
                        prep_cnt          <= '0;
                        ref_begin_prepare <= 1'b1;
                        busy              <= 1'b1;
                        state             <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (scan_init) begin
                        search_column_count <= '0;
                        search_row_count    <= '0;
                        pe_begin_prepare    <= 1'b1;
                        state               <= ST_SCAN;
                    end else begin
                        prep_cnt <= prep_cnt + PW'(1);
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (sad_valid) begin
                        // On the last candidate the counters stay put so IDLE shows the final position.
                        if (col_nxt > {1'b0, w_lat}) begin
                            if (row_nxt > {1'b0, h_lat}) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                search_column_count <= '0;
                                search_row_count    <= row_nxt[ROW_W-1:0];
                            end
                        end else begin
                            search_column_count <= col_nxt[COL_W-1:0];
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PART; p++) begin : g_part
        sad_min_tracker #(
            .SAD_W (SAD_W),
            .COL_W (COL_W),
            .ROW_W (ROW_W)
        ) u_tracker (
            .clk       (clk),
            .rst_n     (rst_n),
            .init      (scan_init),
            .update_en (update_en),
            .sad_in    (sad_in[p*SAD_W +: SAD_W]),
            .col       (search_column_count),
            .row       (search_row_count),
            .best_sad  (best_sad[p*SAD_W +: SAD_W]),
            .best_col  (best_col[p*COL_W +: COL_W]),
            .best_row  (best_row[p*ROW_W +: ROW_W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_scalable_layer_search_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scalable_layer_search_ctrl : directed self-checking bench         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_scalable_layer_search_ctrl;

    localparam int NUM_PART = 7;
    localparam int SAD_W    = 18;
    localparam int COL_W    = 5;
    localparam int ROW_W    = 7;
    localparam int PREP_CYC = 8;
    localparam logic [31:0] ONES = 32'h3FFFF;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      start;
    logic                      abort;
    logic [COL_W-1:0]          search_w;
    logic [ROW_W-1:0]          search_h;
    logic                      step2;
    logic                      sad_valid;
    logic [NUM_PART*SAD_W-1:0] sad_in;
    logic                      ref_begin_prepare;
    logic                      pe_begin_prepare;
    logic [COL_W-1:0]          search_column_count;
    logic [ROW_W-1:0]          search_row_count;
    logic                      busy;
    logic                      done;
    logic [NUM_PART*SAD_W-1:0] best_sad;
    logic [NUM_PART*COL_W-1:0] best_col;
    logic [NUM_PART*ROW_W-1:0] best_row;

    int vectors     = 0;
    int miscompares = 0;

    scalable_layer_search_ctrl #(
        .NUM_PART (NUM_PART),
        .SAD_W    (SAD_W),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W),
        .PREP_CYC (PREP_CYC)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .search_w            (search_w),
        .search_h            (search_h),
        .step2               (step2),
        .sad_valid           (sad_valid),
        .sad_in              (sad_in),
        .ref_begin_prepare   (ref_begin_prepare),
        .pe_begin_prepare    (pe_begin_prepare),
        .search_column_count (search_column_count),
        .search_row_count    (search_row_count),
        .busy                (busy),
        .done                (done),
        .best_sad            (best_sad),
        .best_col            (best_col),
        .best_row            (best_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_part(input int p, input int v);
        sad_in[p*SAD_W +: SAD_W] = SAD_W'(v);
    endtask

    function automatic logic [31:0] bsad(input int p);
        return 32'(best_sad[p*SAD_W +: SAD_W]);
    endfunction

    function automatic logic [31:0] bcol(input int p);
        return 32'(best_col[p*COL_W +: COL_W]);
    endfunction

    function automatic logic [31:0] brow(input int p);
        return 32'(best_row[p*ROW_W +: ROW_W]);
    endfunction

    task automatic begin_search(input int w, input int h, input logic s2);
        search_w = COL_W'(w);
        search_h = ROW_W'(h);
        step2    = s2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_prep(input string tag);
        repeat (PREP_CYC) tick();
        check(tag, 32'(pe_begin_prepare), 32'd1);
    endtask

    initial begin
        int v0[8] = '{9, 7, 7, 5, 6, 5, 8, 9};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; step2 = 1'b0; sad_valid = 1'b0;
        search_w = '0; search_h = '0; sad_in = '1;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ref", 32'(ref_begin_prepare), 32'd0);
        check("rst_col", 32'(search_column_count), 32'd0);
        check("rst_bsad0", bsad(0), ONES);
        check("rst_bcol0", bcol(0), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full search 4x2, prepare-pulse timing
        begin_search(3, 1, 1'b0);
        check("s1_ref", 32'(ref_begin_prepare), 32'd1);
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_pe0", 32'(pe_begin_prepare), 32'd0);
        tick();
        check("s1_ref_off", 32'(ref_begin_prepare), 32'd0);
        repeat (PREP_CYC - 2) tick();
        check("s1_pe_early", 32'(pe_begin_prepare), 32'd0);
        check("s1_busy_prep", 32'(busy), 32'd1);
        tick();
        check("s1_pe", 32'(pe_begin_prepare), 32'd1);
        check("s1_busy_scan", 32'(busy), 32'd1);
        check("s1_bsad_init", bsad(0), ONES);
        for (int i = 0; i < 8; i++) begin
            sad_in = '1;
            set_part(0, v0[i]);
            set_part(1, 100);
            set_part(2, 50 - i);
            sad_valid = 1'b1;
            check("s1_col", 32'(search_column_count), 32'(i % 4));
            check("s1_row", 32'(search_row_count), 32'(i / 4));
            check("s1_nodone", 32'(done), 32'd0);
            tick();
        end
        sad_valid = 1'b0;
        check("s1_done", 32'(done), 32'd1);
        check("s1_busy_end", 32'(busy), 32'd0);
        check("s1_bsad0", bsad(0), 32'd5);
        check("s1_bcol0", bcol(0), 32'd3);
        check("s1_brow0", brow(0), 32'd0);
        check("s1_bsad1", bsad(1), 32'd100);
        check("s1_bcol1", bcol(1), 32'd0);
        check("s1_brow1", brow(1), 32'd0);
        check("s1_bsad2", bsad(2), 32'd43);
        check("s1_bcol2", bcol(2), 32'd3);
        check("s1_brow2", brow(2), 32'd1);
        check("s1_bsad3", bsad(3), ONES);
        sad_in = '1;
        set_part(0, 1);
        sad_valid = 1'b1;
        tick();
        sad_valid = 1'b0;
        check("s1_done_once", 32'(done), 32'd0);
        check("s1_idle_ignore", bsad(0), 32'd5);

        // Step-2 search 5x5 -> 9 candidates; start during PREP is ignored
        begin_search(4, 4, 1'b1);
        check("s2_ref", 32'(ref_begin_prepare), 32'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s2_start_ignored", 32'(ref_begin_prepare), 32'd0);
        repeat (PREP_CYC - 3) tick();
        check("s2_pe_early", 32'(pe_begin_prepare), 32'd0);
        tick();
        check("s2_pe", 32'(pe_begin_prepare), 32'd1);
        for (int i = 0; i < 9; i++) begin
            sad_in = '1;
            set_part(0, (i == 4) ? 10 : 30);
            set_part(1, 100 - i);
            sad_valid = 1'b1;
            check("s2_col", 32'(search_column_count), 32'((i % 3) * 2));
            check("s2_row", 32'(search_row_count), 32'((i / 3) * 2));
            check("s2_nodone", 32'(done), 32'd0);
            tick();
        end
        sad_valid = 1'b0;
        check("s2_done", 32'(done), 32'd1);
        check("s2_bsad0", bsad(0), 32'd10);
        check("s2_bcol0", bcol(0), 32'd2);
        check("s2_brow0", brow(0), 32'd2);
        check("s2_bsad1", bsad(1), 32'd92);
        check("s2_bcol1", bcol(1), 32'd4);
        check("s2_brow1", brow(1), 32'd4);
        tick();

        // Single-candidate search
        begin_search(0, 0, 1'b0);
        run_prep("s5_pe");
        for (int p = 0; p < NUM_PART; p++) set_part(p, 7 + p);
        sad_valid = 1'b1;
        tick();
        sad_valid = 1'b0;
        check("s5_done", 32'(done), 32'd1);
        for (int p = 0; p < NUM_PART; p++) begin
            check("s5_bsad", bsad(p), 32'(7 + p));
            check("s5_bcol", bcol(p), 32'd0);
            check("s5_brow", brow(p), 32'd0);
        end
        tick();

        // Abort together with the third sad_valid
        begin_search(3, 1, 1'b0);
        run_prep("s3_pe");
        sad_in = '1; set_part(0, 10); sad_valid = 1'b1;
        tick();
        sad_in = '1; set_part(0, 4);
        tick();
        sad_in = '1; set_part(0, 1); abort = 1'b1;
        tick();
        abort = 1'b0; sad_valid = 1'b0;
        check("s3_busy", 32'(busy), 32'd0);
        check("s3_done", 32'(done), 32'd0);
        check("s3_bsad0", bsad(0), 32'd4);
        check("s3_bcol0", bcol(0), 32'd1);
        check("s3_brow0", brow(0), 32'd0);
        tick();
        check("s3_done_late", 32'(done), 32'd0);
        check("s3_no_pe", 32'(pe_begin_prepare), 32'd0);
        begin_search(3, 1, 1'b0);
        check("s3_restart_ref", 32'(ref_begin_prepare), 32'd1);
        run_prep("s3_restart_pe");

        // Asynchronous reset mid-SCAN
        sad_in = '1; set_part(0, 2); sad_valid = 1'b1;
        tick();
        sad_valid = 1'b0;
        check("s4_col_pre", 32'(search_column_count), 32'd1);
        check("s4_bsad_pre", bsad(0), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_col", 32'(search_column_count), 32'd0);
        check("s4_row", 32'(search_row_count), 32'd0);
        check("s4_bsad0", bsad(0), ONES);
        check("s4_bcol0", bcol(0), 32'd0);
        check("s4_pulses", 32'({ref_begin_prepare, pe_begin_prepare, done}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("s4_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
